poly_mod_sq_engine: RTL and testbench
=====================================

POLY_MOD_SQ_ENGINE -- requirements
Module: poly_mod_sq_engine

Interface
REQ-001 SHALL have parameter WORD_BITS, default 16: radix bits per coefficient.
REQ-002 SHALL have parameter NUM_WORDS, default 4: number of non-redundant words.
REQ-003 SHALL have parameter MODULUS, default 64'h1FFF_FFFF_FFFF_FFFF, width WORD_BITS*NUM_WORDS: odd modulus.
REQ-004 SHALL have parameter REDUN_WORD_BITS, default 1: redundant bits per coefficient.
REQ-005 SHALL have parameter ITER_BITS, default 16: width of the iteration count.
REQ-006 SHALL derive I_WORD = NUM_WORDS+1 and COEF_BITS = WORD_BITS+REDUN_WORD_BITS; these are not overridable.
REQ-007 SHALL have port i_clk, input, 1 bit: clock.
REQ-008 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-009 SHALL have port i_val, input, 1 bit: request valid.
REQ-010 SHALL have port o_rdy, output, 1 bit: engine can accept a request.
REQ-011 SHALL have port i_mode, input, 2 bits: 0 = multiply, 1 = square, 2 = reduce-only, 3 = reserved (treated as 0).
REQ-012 SHALL have port i_iter, input, ITER_BITS: number of modular operations N (0 treated as 1).
REQ-013 SHALL have port i_dat_a, input, I_WORD*COEF_BITS: operand A, redundant form.
REQ-014 SHALL have port i_dat_b, input, I_WORD*COEF_BITS: operand B, redundant form, ignored in modes 1 and 2.
REQ-015 SHALL have port o_val, output, 1 bit: result valid.
REQ-016 SHALL have port i_rdy, input, 1 bit: downstream accepts the result.
REQ-017 SHALL have port o_dat, output, I_WORD*COEF_BITS: result, redundant form.
REQ-018 SHALL have port o_busy, output, 1 bit: high from accept until the result is taken.

Function
REQ-019 SHALL accept a request on a cycle where i_val && o_rdy, capturing i_mode, i_iter, A and B; o_rdy SHALL be high only in IDLE.
REQ-020 SHALL implement states IDLE, MUL, RED and HOLD, entering IDLE after reset.
- IDLE -> MUL on accept in modes 0, 1 or 3.
- IDLE -> RED on accept in mode 2.
- MUL -> RED after I_WORD cycles.
- RED -> MUL if remaining iterations > 0, else RED -> HOLD.
- HOLD -> IDLE on i_rdy.
REQ-021 SHALL process one operand word per MUL cycle, most-significant word first (word-serial multiply-accumulate with a partial reduction each cycle), then run one RED cycle for the final fold and carry.
REQ-022 SHALL, for modes 0 and 1, assert o_val exactly N*(I_WORD+1)+1 cycles after the accept cycle.
REQ-023 SHALL, for mode 2, assert o_val exactly 2 cycles after the accept cycle.
REQ-024 SHALL compute iteration 1 as P1 = A*B (mode 0) or A*A (mode 1), and every later iteration k as Pk = P(k-1)^2; the intermediate value SHALL be fed back internally.
REQ-025 SHALL produce o_dat with value R = sum(coef_i * 2^(WORD_BITS*i)) satisfying R ≡ P_N (mod MODULUS), every coef_i < 2^COEF_BITS, and R < 2^(WORD_BITS*NUM_WORDS+1); mode 2 gives R ≡ A.
REQ-026 SHALL accept any input whose coefficients fit COEF_BITS, including values >= MODULUS.
REQ-027 SHALL compute the reduction constants (2^(WORD_BITS*k) mod MODULUS) at elaboration; no runtime table loading.
REQ-028 SHALL hold o_val and o_dat stable in HOLD until i_rdy is sampled high; o_val SHALL deassert the cycle after the handshake.
REQ-029 SHALL ignore i_val while o_rdy is low; no queuing.
REQ-030 SHALL NOT accept a new request in the same cycle as the output handshake; earliest new accept is the following cycle.
REQ-031 SHALL drive o_dat to 0 whenever o_val is low.

Reset
REQ-032 SHALL, on i_rst high, force state IDLE, o_val=0, o_dat=0, o_busy=0 and clear the iteration counter and accumulators by the next edge; o_rdy SHALL be 0 while i_rst is high.
REQ-033 SHALL abort any operation in progress when reset is applied mid-operation, with no o_val produced for it; o_rdy=1 on the first cycle after i_rst falls.

Verification (WORD_BITS=16, NUM_WORDS=4, MODULUS=2^61-1, I_WORD=5)
REQ-034 SHALL cover: reset held 3 cycles, then released -> o_val=0, o_dat=0, o_busy=0 during reset; o_rdy=1 the cycle after release.
REQ-035 SHALL cover: mode 0, A=3, B=5, i_iter=1, i_rdy=1 -> o_val at cycle 7 after accept for one cycle; R ≡ 15 (mod M).
REQ-036 SHALL cover: mode 1, A=2, i_iter=10 -> o_val at cycle 61; R ≡ 2^48 (mod M); i_iter=0 behaves as i_iter=1 (cycle 7, R ≡ 4).
REQ-037 SHALL cover: mode 2, A = M+7 with a redundant top coefficient -> o_val at cycle 2; R ≡ 7; every coef < 2^17.
REQ-038 SHALL cover: i_rdy held low 5 cycles after o_val -> o_val and o_dat stable, o_rdy=0, and a second i_val during this window ignored; a new accept occurs only the cycle after the handshake.
REQ-039 SHALL cover: mode 1, i_iter=10, reset asserted at cycle 20 -> no o_val; o_rdy=1 after release; a following mode 0 3*5 request returns R ≡ 15 at cycle 7.

Source files
------------

// File: rtl/poly_mod_sq_engine.sv
// Word-serial modular multiply / iterated-square engine. Operands and results
// use a redundant radix-2^WORD_BITS form with COEF_BITS-wide coefficients.
module poly_mod_sq_engine #(
  parameter int WORD_BITS = 16,
  parameter int NUM_WORDS = 4,
  parameter logic [WORD_BITS*NUM_WORDS-1:0] MODULUS = 64'h1FFF_FFFF_FFFF_FFFF,
  parameter int REDUN_WORD_BITS = 1,
  parameter int ITER_BITS = 16,
  localparam int I_WORD = NUM_WORDS + 1,
  localparam int COEF_BITS = WORD_BITS + REDUN_WORD_BITS
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_val,
  output logic                        o_rdy,
  input  logic [1:0]                  i_mode,
  input  logic [ITER_BITS-1:0]        i_iter,
  input  logic [I_WORD*COEF_BITS-1:0] i_dat_a,
  input  logic [I_WORD*COEF_BITS-1:0] i_dat_b,
  output logic                        o_val,
  input  logic                        i_rdy,
  output logic [I_WORD*COEF_BITS-1:0] o_dat,
  output logic                        o_busy,
  output logic [1:0]                  o_dbg_state
);

  localparam int MW  = WORD_BITS * NUM_WORDS;
  localparam int DW  = I_WORD * COEF_BITS;
  localparam int BW  = COEF_BITS + MW + 1;
  localparam int AW  = MW + WORD_BITS + 3;
  localparam int TW  = MW + 2 * WORD_BITS + 2 * REDUN_WORD_BITS + 4;
  localparam int NF  = (TW - MW + WORD_BITS - 1) / WORD_BITS;
  localparam int MUW = 2 * MW + 1;
  localparam int CW  = $clog2(I_WORD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RED  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // 2^e mod MODULUS by repeated doubling; only evaluated at elaboration.
  function automatic logic [MW-1:0] pow2_mod(input int e);
    logic [MW:0] r;
    r = (MW+1)'(1);
    if (r >= {1'b0, MODULUS}) r = r - {1'b0, MODULUS};
    for (int i = 0; i < e; i++) begin
      r = r << 1;
      if (r >= {1'b0, MODULUS}) r = r - {1'b0, MODULUS};
    end
    return MW'(r);
  endfunction

  function automatic logic [MUW-1:0] calc_mu();
    logic [MUW-1:0] num;
    num = '0;
    num[2*MW] = 1'b1;
    return num / MUW'(MODULUS);
  endfunction

  function automatic logic [BW-1:0] red_value(input logic [DW-1:0] d);
    logic [BW-1:0] v;
    v = '0;
    for (int i = 0; i < I_WORD; i++)
      v = v + (BW'(d[i*COEF_BITS +: COEF_BITS]) << (i * WORD_BITS));
    return v;
  endfunction

  localparam logic [MUW-1:0] MU = calc_mu();

  // Fold constants for the word positions that sit above the modulus width.
  logic [MW-1:0] fold_c [NF];
  for (genvar g = 0; g < NF; g++) begin : g_fold_c
    localparam logic [MW-1:0] FOLD_CONST = pow2_mod(WORD_BITS * (NUM_WORDS + g));
    assign fold_c[g] = FOLD_CONST;
  end

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ITER_BITS-1:0]   iter_q, iter_d;
  logic [DW-1:0]          a_q, a_d;
  logic [DW-1:0]          b_q, b_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [DW-1:0]          res_q, res_d;

  logic [BW-1:0]          b_val;
  logic [TW-1:0]          mac_t;
  logic [AW-1:0]          mac_fold;
  logic [MW:0]            red_r2;
  logic [MW-1:0]          red_r;
  logic [DW-1:0]          red_dat;

  // Horner step on the most-significant remaining word of A, then fold every
  // word above the modulus width back in with its 2^(W*k) mod M constant.
  always_comb begin : p_mac
    logic [NF*WORD_BITS-1:0] hi;
    b_val    = red_value(b_q);
    mac_t    = (TW'(acc_q) << WORD_BITS) + TW'(a_q[DW-1 -: COEF_BITS]) * TW'(b_val);
    hi       = (NF*WORD_BITS)'(mac_t >> MW);
    mac_fold = AW'(mac_t[MW-1:0]);
    for (int j = 0; j < NF; j++)
      mac_fold = mac_fold + AW'(hi[j*WORD_BITS +: WORD_BITS]) * AW'(fold_c[j]);
  end

  // Final reduction: Barrett quotient estimate is at most one short, so a
  // single conditional subtract lands the remainder in [0, M).
  always_comb begin : p_red
    logic [AW-1:0] q;
    q       = AW'(((AW+MUW)'(acc_q) * (AW+MUW)'(MU)) >> (2 * MW));
    red_r2  = (MW+1)'(acc_q - AW'(q * AW'(MODULUS)));
    red_r   = (red_r2 >= {1'b0, MODULUS}) ? MW'(red_r2 - {1'b0, MODULUS}) : MW'(red_r2);
    red_dat = '0;
    for (int i = 0; i < NUM_WORDS; i++)
      red_dat[i*COEF_BITS +: COEF_BITS] = COEF_BITS'(red_r[i*WORD_BITS +: WORD_BITS]);
  end

  // Handshakes: a request transfers on a cycle with i_val && o_rdy; a result
  // transfers on a cycle with o_val && i_rdy. Neither side may retract early.
  always_comb begin : p_fsm
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (i_val) begin
          a_d   = i_dat_a;
          b_d   = (i_mode == 2'd1) ? i_dat_a : i_dat_b;
          cnt_d = '0;
          if (i_mode == 2'd2) begin
            acc_d   = AW'(red_value(i_dat_a));
            iter_d  = ITER_BITS'(1);
            state_d = ST_RED;
          end else begin
            acc_d   = '0;
            iter_d  = (i_iter == '0) ? ITER_BITS'(1) : i_iter;
            state_d = ST_MUL;
          end
        end
      end
      ST_MUL: begin
        acc_d = mac_fold;
        a_d   = a_q << COEF_BITS;
        if (cnt_q == CW'(I_WORD - 1)) begin
          cnt_d   = '0;
          state_d = ST_RED;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RED: begin
        res_d = red_dat;
        if (iter_q > ITER_BITS'(1)) begin
          iter_d  = iter_q - ITER_BITS'(1);
          a_d     = red_dat;
          b_d     = red_dat;
          acc_d   = '0;
          state_d = ST_MUL;
        end else begin
          iter_d  = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_rdy) begin
          res_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign o_rdy       = (state_q == ST_IDLE) && !i_rst;
  assign o_val       = (state_q == ST_HOLD) && !i_rst;
  assign o_busy      = (state_q != ST_IDLE) && !i_rst;
  assign o_dat       = o_val ? res_q : '0;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_poly_mod_sq_engine.sv
// Self-checking bench for poly_mod_sq_engine against a plain-arithmetic
// modular exponent model at the default 16x4, M = 2^61-1 configuration.
module tb_poly_mod_sq_engine;

  localparam int WB = 16;
  localparam int CB = 17;
  localparam int IW = 5;
  localparam int DW = IW * CB;
  localparam logic [127:0] M = 128'h1FFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] R_LIMIT = 128'd1 << 65;

  logic          i_clk, i_rst, i_val, i_rdy;
  logic          o_rdy, o_val, o_busy;
  logic [1:0]    i_mode;
  logic [15:0]   i_iter;
  logic [DW-1:0] i_dat_a, i_dat_b, o_dat;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;

  poly_mod_sq_engine dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .o_rdy(o_rdy),
    .i_mode(i_mode), .i_iter(i_iter), .i_dat_a(i_dat_a), .i_dat_b(i_dat_b),
    .o_val(o_val), .i_rdy(i_rdy), .o_dat(o_dat), .o_busy(o_busy),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [127:0] op_value(input logic [DW-1:0] d);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < IW; i++) v = v + (128'(d[i*CB +: CB]) << (WB * i));
    return v;
  endfunction

  function automatic logic [127:0] ref_result(input logic [1:0] mode, input logic [15:0] iter,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [127:0] av, bv, p;
    int n;
    av = op_value(a) % M;
    bv = op_value(b) % M;
    if (mode == 2'd2) return av;
    n = (iter == 16'd0) ? 1 : int'(iter);
    p = (mode == 2'd1) ? (av * av) % M : (av * bv) % M;
    for (int k = 1; k < n; k++) p = (p * p) % M;
    return p;
  endfunction

  function automatic int ref_latency(input logic [1:0] mode, input logic [15:0] iter);
    if (mode == 2'd2) return 2;
    return ((iter == 16'd0) ? 1 : int'(iter)) * (IW + 1) + 1;
  endfunction

  function automatic logic [DW-1:0] rand_op();
    logic [DW-1:0] d;
    for (int i = 0; i < IW; i++) d[i*CB +: CB] = CB'($urandom_range(0, (1 << CB) - 1));
    return d;
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge of cycle 1 after the accept.
  task automatic accept_req(input logic [1:0] mode, input logic [15:0] iter,
                            input logic [DW-1:0] a, input logic [DW-1:0] b, output logic ok);
    int w;
    w = 0;
    while (o_rdy !== 1'b1 && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    ok      = (o_rdy === 1'b1);
    i_val   = 1'b1;
    i_mode  = mode;
    i_iter  = iter;
    i_dat_a = a;
    i_dat_b = b;
    @(posedge i_clk);
    @(negedge i_clk);
    i_val = 1'b0;
  endtask

  // Returns at the negedge where o_val is first seen (lat = cycles since accept).
  task automatic wait_val(input int max_cyc, output int lat, output int bad);
    lat = -1;
    bad = 0;
    for (int n = 1; n <= max_cyc && lat < 0; n++) begin
      if (o_val === 1'b1) begin
        lat = n;
      end else begin
        if (o_busy !== 1'b1 || o_rdy !== 1'b0 || o_dat !== '0) bad++;
        @(negedge i_clk);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      checks++; if (o_val !== 1'b0) begin failures++; $display("FAIL reset_o_val: got %b want 0", o_val); end
      checks++; if (o_dat !== '0) begin failures++; $display("FAIL reset_o_dat: got %0h want 0", o_dat); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_o_busy: got %b want 0", o_busy); end
      checks++; if (o_rdy !== 1'b0) begin failures++; $display("FAIL reset_o_rdy: got %b want 0", o_rdy); end
    end
    i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL release_o_rdy: got %b want 1", o_rdy); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL release_o_busy: got %b want 0", o_busy); end
  endtask

  task automatic test_mul_basic();
    logic ok;
    int lat, bad;
    logic [127:0] r;
    accept_req(2'd0, 16'd1, DW'(3), DW'(5), ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mul_accept: got %b want 1", ok); end
    wait_val(40, lat, bad);
    checks++; if (lat != 7) begin failures++; $display("FAIL mul_latency: got %0d want 7", lat); end
    checks++; if (bad != 0) begin failures++; $display("FAIL mul_busy_window: got %0d bad cycles want 0", bad); end
    r = op_value(o_dat);
    checks++; if (r % M !== 128'd15) begin failures++; $display("FAIL mul_value: got %0h want 15", r % M); end
    checks++; if (r >= R_LIMIT) begin failures++; $display("FAIL mul_range: got %0h want < 2^65", r); end
    @(posedge i_clk);
    @(negedge i_clk);
    checks++; if (o_val !== 1'b0) begin failures++; $display("FAIL mul_one_cycle: got %b want 0", o_val); end
    checks++; if (o_dat !== '0) begin failures++; $display("FAIL mul_dat_idle: got %0h want 0", o_dat); end
  endtask

  task automatic test_square_iter();
    logic ok;
    int lat, bad;
    logic [127:0] r;
    accept_req(2'd1, 16'd10, DW'(2), DW'(12345), ok);
    wait_val(100, lat, bad);
    checks++; if (lat != 61) begin failures++; $display("FAIL sq10_latency: got %0d want 61", lat); end
    r = op_value(o_dat);
    checks++; if (r % M !== (128'd1 << 48)) begin failures++; $display("FAIL sq10_value: got %0h want 2^48", r % M); end
    @(posedge i_clk);
    @(negedge i_clk);
    accept_req(2'd1, 16'd0, DW'(2), DW'(9), ok);
    wait_val(40, lat, bad);
    checks++; if (lat != 7) begin failures++; $display("FAIL sq0_latency: got %0d want 7", lat); end
    r = op_value(o_dat);
    checks++; if (r % M !== 128'd4) begin failures++; $display("FAIL sq0_value: got %0h want 4", r % M); end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reduce_only();
    logic ok;
    int lat, bad;
    logic [127:0] r;
    logic [DW-1:0] a;
    // M + 7 = 2^61 + 6 with coefficient 2 using its redundant bit.
    a = '0;
    a[0*CB +: CB] = CB'(6);
    a[2*CB +: CB] = CB'(65536);
    a[3*CB +: CB] = CB'(8191);
    accept_req(2'd2, 16'd5, a, rand_op(), ok);
    wait_val(20, lat, bad);
    checks++; if (lat != 2) begin failures++; $display("FAIL red_latency: got %0d want 2", lat); end
    r = op_value(o_dat);
    checks++; if (r % M !== 128'd7) begin failures++; $display("FAIL red_value: got %0h want 7", r % M); end
    checks++; if (r >= R_LIMIT) begin failures++; $display("FAIL red_range: got %0h want < 2^65", r); end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_backpressure();
    logic ok;
    int lat, bad;
    logic [DW-1:0] a, b, held;
    logic [127:0] exp_r, r;
    a = rand_op();
    b = rand_op();
    exp_r = ref_result(2'd0, 16'd2, a, b);
    i_rdy = 1'b0;
    accept_req(2'd0, 16'd2, a, b, ok);
    wait_val(60, lat, bad);
    checks++; if (lat != 13) begin failures++; $display("FAIL bp_latency: got %0d want 13", lat); end
    held = o_dat;
    r = op_value(held);
    checks++; if (r % M !== exp_r) begin failures++; $display("FAIL bp_value: got %0h want %0h", r % M, exp_r); end
    i_val = 1'b1; i_mode = 2'd0; i_iter = 16'd1; i_dat_a = DW'(3); i_dat_b = DW'(5);
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      checks++; if (o_val !== 1'b1) begin failures++; $display("FAIL bp_hold_val: got %b want 1", o_val); end
      checks++; if (o_dat !== held) begin failures++; $display("FAIL bp_hold_dat: got %0h want %0h", o_dat, held); end
      checks++; if (o_rdy !== 1'b0) begin failures++; $display("FAIL bp_hold_rdy: got %b want 0", o_rdy); end
    end
    i_dat_a = DW'(6); i_dat_b = DW'(7); i_rdy = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    checks++; if (o_val !== 1'b0) begin failures++; $display("FAIL bp_release_val: got %b want 0", o_val); end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL bp_no_same_cycle_accept: got busy %b want 0", o_busy); end
    checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy_after: got %b want 1", o_rdy); end
    @(posedge i_clk);
    @(negedge i_clk);
    i_val = 1'b0;
    wait_val(40, lat, bad);
    checks++; if (lat != 7) begin failures++; $display("FAIL bp_next_latency: got %0d want 7", lat); end
    r = op_value(o_dat);
    checks++; if (r % M !== 128'd42) begin failures++; $display("FAIL bp_next_value: got %0h want 42", r % M); end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid();
    logic ok;
    int lat, bad, vcount;
    logic [127:0] r;
    vcount = 0;
    accept_req(2'd1, 16'd10, DW'(2), DW'(0), ok);
    for (int n = 1; n < 20; n++) begin
      if (o_val === 1'b1) vcount++;
      @(negedge i_clk);
    end
    i_rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_val === 1'b1) vcount++;
    end
    checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", o_busy); end
    i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL rmid_rdy: got %b want 1", o_rdy); end
    for (int n = 0; n < 60; n++) begin
      if (o_val === 1'b1) vcount++;
      @(negedge i_clk);
    end
    checks++; if (vcount != 0) begin failures++; $display("FAIL rmid_no_val: got %0d valid cycles want 0", vcount); end
    accept_req(2'd0, 16'd1, DW'(3), DW'(5), ok);
    wait_val(40, lat, bad);
    checks++; if (lat != 7) begin failures++; $display("FAIL rmid_next_latency: got %0d want 7", lat); end
    r = op_value(o_dat);
    checks++; if (r % M !== 128'd15) begin failures++; $display("FAIL rmid_next_value: got %0h want 15", r % M); end
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_random();
    logic ok;
    int lat, bad, exp_lat;
    logic [1:0] mode;
    logic [15:0] iter;
    logic [DW-1:0] a, b;
    logic [127:0] exp_r, r;
    for (int t = 0; t < 12; t++) begin
      mode    = 2'($urandom_range(0, 3));
      iter    = 16'($urandom_range(0, 4));
      a       = rand_op();
      b       = rand_op();
      exp_r   = ref_result(mode, iter, a, b);
      exp_lat = ref_latency(mode, iter);
      accept_req(mode, iter, a, b, ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rnd_accept[%0d]: got %b want 1", t, ok); end
      wait_val(exp_lat + 20, lat, bad);
      checks++; if (lat != exp_lat) begin failures++; $display("FAIL rnd_latency[%0d]: mode %0d got %0d want %0d", t, mode, lat, exp_lat); end
      checks++; if (bad != 0) begin failures++; $display("FAIL rnd_busy_window[%0d]: got %0d bad cycles want 0", t, bad); end
      r = op_value(o_dat);
      checks++; if (r % M !== exp_r) begin failures++; $display("FAIL rnd_value[%0d]: mode %0d got %0h want %0h", t, mode, r % M, exp_r); end
      checks++; if (r >= R_LIMIT) begin failures++; $display("FAIL rnd_range[%0d]: got %0h want < 2^65", t, r); end
      @(posedge i_clk);
      @(negedge i_clk);
      checks++; if (o_val !== 1'b0) begin failures++; $display("FAIL rnd_one_cycle[%0d]: got %b want 0", t, o_val); end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    i_rst   = 1'b1;
    i_val   = 1'b0;
    i_rdy   = 1'b1;
    i_mode  = 2'd0;
    i_iter  = 16'd0;
    i_dat_a = '0;
    i_dat_b = '0;
    test_reset();
    test_mul_basic();
    test_square_iter();
    test_reduce_only();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
